// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          WORD_W               = 32;
    localparam int          ADDR_W               = 16;
    localparam logic [31:0] PC_STEP              = 32'd4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic              fault;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] data;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [WORD_W-1:0] byte_pc);
        return byte_pc[ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched entries with push/pop/flush; push and pop may coincide at any occupancy.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    // NOTE: storage is deliberately not reset; count/pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = storage[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    push_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, sequential SRAM reads, response buffer, redirect with flush.
// Optional out-of-range fault generation is enabled by defining FETCH_BOUND_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int          FIFO_DEPTH   = 2,
    parameter int          MEM_WORDS    = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [31:0]       mem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
    output logic              inst_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MEM_WORDS < 1) begin : g_param_check
        $error("fetch_unit: FIFO_DEPTH must be a power of two >= 2 and MEM_WORDS >= 1");
    end

    logic [31:0]      pc;
    logic [31:0]      issue_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic             issue;
    logic             oob;
    logic             pop;
    logic             push;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        issue_pc = pc;
        if (redirect_valid) begin
            issue_pc = {redirect_pc[31:2], 2'b00};
        end
    end

    assign mem_address = word_addr(issue_pc);
    assign inst_valid  = !empty && !redirect_valid;
    assign pop         = inst_valid && inst_ready;

    // Buffered + in-flight entries, less the one leaving now, must leave room for a new response.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign issue     = rst && fetch_en && (redirect_valid || occupancy < OCC_W'(FIFO_DEPTH));
    assign mem_rd_en = issue && !oob;

    // A redirect kills the response of any earlier issue; the target's own response lands next cycle.
    assign push = inflight && !redirect_valid;

`ifdef FETCH_BOUND_CHECK_EN
    logic inflight_fault;

    assign oob = issue_pc[31:2] >= 30'(MEM_WORDS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_fault <= 1'b0;
        end else begin
            inflight_fault <= issue && oob;
        end
    end

    assign push_entry.fault = inflight_fault;
    assign push_entry.pc    = inflight_pc;
    assign push_entry.data  = inflight_fault ? '0 : mem_data;
    assign inst_fault       = inst_valid && head.fault;
`else
    logic unused_fault;

    assign oob              = 1'b0;
    assign push_entry.fault = 1'b0;
    assign push_entry.pc    = inflight_pc;
    assign push_entry.data  = mem_data;
    assign inst_fault       = 1'b0;
    assign unused_fault     = head.fault;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_VECTOR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= issue_pc + PC_STEP;
                inflight_pc <= issue_pc;
            end else if (redirect_valid) begin
                pc <= issue_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    assign inst_data = inst_valid ? head.data : '0;
    assign inst_pc   = inst_valid ? head.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences and a randomized run
// checked by a stream-level model (expected next PC, SRAM contents, fault rule).
module tb_fetch_unit;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          DEPTH = 2;
    localparam int          MEMW  = 16384;
`ifdef FETCH_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_rd_en;
    logic [15:0] mem_address;
    logic [31:0] mem_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_VECTOR(RV),
        .FIFO_DEPTH  (DEPTH),
        .MEM_WORDS   (MEMW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_rd_en     (mem_rd_en),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_fault    (inst_fault)
    );

    function automatic logic [31:0] word_of(input logic [15:0] a);
        case (a)
            16'd0:   return 32'hE3A0_0001;
            16'd1:   return 32'hE3A0_1002;
            16'd2:   return 32'hE080_2001;
            16'd3:   return 32'hEAFF_FFFE;
            default: return {a ^ 16'h5A5A, a};
        endcase
    endfunction

    function automatic logic exp_fault(input logic [31:0] p);
        return BOUND && (p[31:2] >= 30'(MEMW));
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] p);
        return exp_fault(p) ? 32'h0 : word_of(p[17:2]);
    endfunction

    // SRAM model: one-cycle registered read
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= word_of(mem_address);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Stream model: every accepted instruction must be the next sequential PC (or the redirect target)
    // carrying the SRAM word at that address; stalled outputs must hold.
    initial begin : scoreboard
        logic [31:0] exp_pc;
        bit          stall_prev;
        logic [31:0] stall_pc;
        logic [31:0] stall_data;
        exp_pc     = RV;
        stall_prev = 1'b0;
        stall_pc   = '0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_pc     = RV;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && !redirect_valid) begin
                    check("hold_valid", inst_valid, 1);
                    check("hold_pc", inst_pc, stall_pc);
                    check("hold_data", inst_data, stall_data);
                end
                if (!fetch_en) check("paused_rd_en", mem_rd_en, 0);
                if (redirect_valid) begin
                    check("redir_valid_gate", inst_valid, 0);
                    check("redir_addr", {16'h0, mem_address}, {16'h0, redirect_pc[17:2]});
                    if (fetch_en)
                        check("redir_rd_en", mem_rd_en, !exp_fault({redirect_pc[31:2], 2'b00}));
                    exp_pc     = {redirect_pc[31:2], 2'b00};
                    stall_prev = 1'b0;
                end else begin
                    if (inst_valid && inst_ready) begin
                        check("stream_pc", inst_pc, exp_pc);
                        check("stream_data", inst_data, exp_word(exp_pc));
                        check("stream_fault", inst_fault, exp_fault(exp_pc));
                        exp_pc = exp_pc + 32'd4;
                        n_pops++;
                    end
                    stall_prev = inst_valid && !inst_ready;
                    stall_pc   = inst_pc;
                    stall_data = inst_data;
                end
            end
        end
    end

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_data;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic e_rd, input logic [15:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.fe = 1'b1; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_data  = exp_word(e_pc);
        v.e_fault = exp_fault(e_pc);
        return v;
    endfunction

    initial begin
        // cycles after reset release: startup, 6-cycle stall, redirects, aligned/misaligned/out-of-range targets
        vecs.push_back(mk(1, 0, 0, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0001, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0002, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0003, 1, 32'h4));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0004, 1, 32'h8));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0005, 1, 32'hC));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 0, 0, 16'h0006, 1, 32'h10));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0006, 1, 32'h10));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0007, 1, 32'h14));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0008, 1, 32'h18));
        vecs.push_back(mk(1, 1, 32'h100, 1, 16'h0040, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0041, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0042, 1, 32'h100));
        vecs.push_back(mk(1, 1, 32'h103, 1, 16'h0040, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0041, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 16'h0042, 1, 32'h100));
        vecs.push_back(mk(1, 1, 32'h10000, !BOUND, 16'h4000, 0, 0));
        vecs.push_back(mk(1, 0, 0, !BOUND, 16'h4001, 0, 0));
        vecs.push_back(mk(1, 0, 0, !BOUND, 16'h4002, 1, 32'h10000));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_data", inst_data, 0);
        check("rst_fault", inst_fault, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            if (i == 0) rst = 1'b1;
            fetch_en       = vecs[i].fe;
            inst_ready     = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            check($sformatf("vec%0d_rd_en", i), mem_rd_en, vecs[i].e_rd);
            check($sformatf("vec%0d_addr", i), {16'h0, mem_address}, {16'h0, vecs[i].e_addr});
            check($sformatf("vec%0d_valid", i), inst_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_pc", i), inst_pc, vecs[i].e_pc);
                check($sformatf("vec%0d_data", i), inst_data, vecs[i].e_data);
                check($sformatf("vec%0d_fault", i), inst_fault, vecs[i].e_fault);
            end
        end

        // fetch_en low: no issue, outstanding response still lands and the buffer drains
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            fetch_en       = 1'b0;
            inst_ready     = 1'b1;
            redirect_valid = 1'b0;
            @(negedge clk);
            check("pause_rd_en", mem_rd_en, 0);
        end
        check("pause_drained", inst_valid, 0);
        @(posedge clk);
        #1;
        fetch_en = 1'b1;
        @(negedge clk);
        check("resume_rd_en", mem_rd_en, !BOUND);
        check("resume_addr", {16'h0, mem_address}, 32'h0000_4003);

        // fill the buffer, then reset asynchronously mid-cycle
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            inst_ready = 1'b0;
            @(negedge clk);
        end
        check("full_valid", inst_valid, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", inst_valid, 0);
        check("async_rst_rd_en", mem_rd_en, 0);
        check("async_rst_pc", inst_pc, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        check("post_rst_rd_en", mem_rd_en, 1);
        check("post_rst_addr", {16'h0, mem_address}, {16'h0, RV[17:2]});

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            fetch_en       = ($urandom_range(0, 7) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom & 32'h0000_FFFF;
                1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                2:       redirect_pc = $urandom;
                default: redirect_pc = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
            endcase
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        @(negedge clk);
        check("stream_progress", 32'(n_pops > 500), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
